rdport_collector: RTL and testbench

//   Read-port front end for the multi-agent RAM, one instance per read agent,

---
 rtl/meduram_pkg.sv | 15 +
 rtl/rdport_fifo.sv | 66 ++++++
 rtl/rdport_collector.sv | 104 ++++++++++
 tb/tb_rdport_collector.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/meduram_pkg.sv
// Shared sizing helpers and defaults for the multi-agent RAM read-port logic.
package meduram_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  // A single bank still needs a 1-bit selector port.
  function automatic int sel_width(input int nb);
    return (nb <= 1) ? 1 : $clog2(nb);
  endfunction

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rdport_fifo.sv
// Synchronous show-ahead FIFO: head word is visible combinationally while not empty.
module rdport_fifo
  import meduram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic             aclk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] head_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = credit_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_eff;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign head_data = mem_q[rd_ptr_q];
  assign pop_eff   = pop & ~empty;

  always_comb begin
    wr_ptr_d = push    ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_eff ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop_eff})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // Credits upstream make a push into a full FIFO without a pop unreachable.
  a_no_overflow: assert property (@(posedge aclk) disable iff (srst) !(push && full && !pop));

endmodule

// File: rtl/rdport_collector.sv
// Per-read-agent front end: credit-gated issue, latency-aligned bank select, ordered responses.
module rdport_collector
  import meduram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
  parameter int NB_WRAGENT   = 2,
  parameter int SELECT_WIDTH = sel_width(NB_WRAGENT),
  parameter int RAM_LATENCY  = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             aclk,
  input  logic                             srst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             rden,
  output logic [ADDR_WIDTH-1:0]            rdaddr,
  input  logic [SELECT_WIDTH-1:0]          rdselect,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0] bank_rddata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             sel_err
);

  localparam int CW = credit_width(FIFO_DEPTH);

  if (FIFO_DEPTH < RAM_LATENCY + 1) begin : g_depth_chk
    $error("rdport_collector: FIFO_DEPTH must be >= RAM_LATENCY+1");
  end

  logic [CW-1:0]          credits_q, credits_d;
  logic [RAM_LATENCY-1:0] vld_q, vld_d;
  logic                   sel_err_q, sel_err_d;
  logic                   acc, pop, push, sel_bad, fifo_empty, fifo_full;
  logic [DATA_WIDTH-1:0]  push_data;

  assign req_ready = (credits_q != '0) & ~srst;
  assign acc       = req_valid & req_ready;
  assign rden      = acc;
  assign rdaddr    = req_addr;
  assign rsp_valid = ~fifo_empty;
  assign pop       = rsp_valid & rsp_ready;
  assign sel_err   = sel_err_q;

  // Valid shift register: stage k holds reads issued k+1 cycles ago.
  assign vld_d[0] = acc;
  for (genvar gi = 1; gi < RAM_LATENCY; gi++) begin : g_stage
    assign vld_d[gi] = vld_q[gi-1];
  end
  assign push = vld_q[RAM_LATENCY-1];

  assign sel_bad = (int'(rdselect) >= NB_WRAGENT);

  always_comb begin
    push_data = '0;
    for (int b = 0; b < NB_WRAGENT; b++) begin
      if (int'(rdselect) == b) push_data = bank_rddata[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    credits_d = credits_q;
    case ({acc, pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
    sel_err_d = sel_err_q | (push & sel_bad);
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      credits_q <= CW'(FIFO_DEPTH);
      vld_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      credits_q <= credits_d;
      vld_q     <= vld_d;
      sel_err_q <= sel_err_d;
    end
  end

  rdport_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .aclk      (aclk),
    .srst      (srst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .head_data (rsp_data)
  );

  a_credit_hi: assert property (@(posedge aclk) disable iff (srst)
    !(pop && !acc && credits_q == CW'(FIFO_DEPTH)));
  a_credit_lo: assert property (@(posedge aclk) disable iff (srst)
    !(acc && credits_q == '0));

endmodule

// File: tb/tb_rdport_collector.sv
// Randomized bench: acts as the RAM banks and checks every cycle against a queue-based model.
module tb_rdport_collector;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NB = 3;
  localparam int SW = 2;
  localparam int L  = 1;
  localparam int D  = 4;

  logic           aclk = 1'b0;
  logic           srst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [AW-1:0]  req_addr = '0;
  logic           rden;
  logic [AW-1:0]  rdaddr;
  logic [SW-1:0]  rdselect = '0;
  logic [NB*DW-1:0] bank_rddata = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DW-1:0]  rsp_data;
  logic           sel_err;

  rdport_collector #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .NB_WRAGENT  (NB),
    .RAM_LATENCY (L),
    .FIFO_DEPTH  (D)
  ) dut (
    .aclk        (aclk),
    .srst        (srst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rden        (rden),
    .rdaddr      (rdaddr),
    .rdselect    (rdselect),
    .bank_rddata (bank_rddata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .sel_err     (sel_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    int            vis;
  } rsp_t;

  typedef struct {
    logic [SW-1:0]    sel;
    logic [NB*DW-1:0] bank;
    int               due;
  } rd_t;

  rsp_t exp_q[$];
  rd_t  ram_q[$];
  bit   err_m = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   n_rsp = 0;

  function automatic logic [DW-1:0] pick(input logic [SW-1:0] sel, input logic [NB*DW-1:0] bk);
    if (int'(sel) < NB) return bk[int'(sel)*DW +: DW];
    return '0;
  endfunction

  function automatic logic [NB*DW-1:0] rbank();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive, compare at negedge, update model at the rising edge.
  task automatic step(input bit v, input logic [AW-1:0] a, input bit r,
                      input logic [SW-1:0] s, input logic [NB*DW-1:0] bk);
    rd_t due_e;
    bit  have_due, exp_rdy, acc, vis, bad;
    req_valid = v;
    req_addr  = a;
    rsp_ready = r;
    have_due  = (ram_q.size() > 0) && (ram_q[0].due == cyc);
    if (have_due) begin
      due_e       = ram_q.pop_front();
      rdselect    = due_e.sel;
      bank_rddata = due_e.bank;
    end else begin
      rdselect    = SW'($urandom_range(0, 3));
      bank_rddata = rbank();
    end
    @(negedge aclk);
    exp_rdy = !srst && (exp_q.size() < D);
    acc     = v && exp_rdy;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rden", 32'(rden), 32'(acc));
    if (acc) check("rdaddr", 32'(rdaddr), 32'(a));
    vis = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
    check("rsp_valid", 32'(rsp_valid), 32'(vis));
    if (vis) check("rsp_data", rsp_data, exp_q[0].data);
    check("sel_err", 32'(sel_err), 32'(err_m));
    if (vis && r) begin
      $display("rsp %0d: data=%h cycle=%0d", n_rsp, exp_q[0].data, cyc);
      void'(exp_q.pop_front());
      n_rsp++;
    end
    if (acc) begin
      n_acc++;
      ram_q.push_back('{s, bk, cyc + L});
      exp_q.push_back('{pick(s, bk), cyc + L + 1});
    end
    bad = have_due && (int'(due_e.sel) >= NB);
    @(posedge aclk);
    if (srst) begin
      exp_q.delete();
      ram_q.delete();
      err_m = 1'b0;
    end else if (bad) begin
      err_m = 1'b1;
    end
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, '0, '0);
  endtask

  initial begin
    int n0;
    @(posedge aclk);
    #1;
    // Reset held with a pending request: nothing may be accepted or issued.
    for (int i = 0; i < 3; i++) step(1'b1, AW'($urandom), 1'b1, '0, rbank());
    srst = 1'b0;

    // Single read, bank 1 wins.
    step(1'b1, 8'h10, 1'b1, 2'd1, {32'h0, 32'hCAFE0001, 32'h0000DEAD});
    idle(3);

    // Back-to-back streaming with alternating select.
    for (int i = 0; i < 16; i++) step(1'b1, AW'(i), 1'b1, SW'(i % 2), rbank());
    idle(3);

    // Backpressure: exactly D accepts, then one pop reopens exactly one.
    n0 = n_acc;
    for (int i = 0; i < 8; i++) step(1'b1, AW'($urandom), 1'b0, SW'($urandom_range(0, 2)), rbank());
    check("bp_accepts", n_acc - n0, 32'(D));
    n0 = n_acc;
    step(1'b1, AW'($urandom), 1'b1, SW'($urandom_range(0, 2)), rbank());
    for (int i = 0; i < 4; i++) step(1'b1, AW'($urandom), 1'b0, SW'($urandom_range(0, 2)), rbank());
    check("bp_reopen", n_acc - n0, 32'd1);

    // Full FIFO, zero credits: sustained accept+pop.
    for (int i = 0; i < 8; i++) step(1'b1, AW'($urandom), 1'b1, SW'($urandom_range(0, 2)), rbank());
    idle(4);

    // Out-of-range select returns zero and latches sel_err.
    step(1'b1, 8'h33, 1'b1, 2'd3, rbank());
    for (int i = 0; i < 10; i++) step(1'b1, AW'($urandom), 1'b1, SW'($urandom_range(0, 2)), rbank());
    check("sel_err_sticky", 32'(sel_err), 32'd1);

    // Reset with two reads pending: no stale responses afterwards.
    step(1'b1, 8'h41, 1'b0, 2'd0, rbank());
    step(1'b1, 8'h42, 1'b0, 2'd1, rbank());
    srst = 1'b1;
    step(1'b0, '0, 1'b0, '0, '0);
    srst = 1'b0;
    idle(5);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, AW'($urandom), $urandom_range(0, 3) != 0,
           SW'($urandom_range(0, 2)), rbank());
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
